// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Holds the FSM state encoding, the ALU opcode map and the flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_OP,
    S_EXEC,
    S_SHOW
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Entry step shown to the user; EXEC and SHOW share the last step.
  function automatic logic [1:0] stage_of(input state_t s);
    logic [1:0] st;
    st = 2'd3;
    case (s)
      S_A:     st = 2'd0;
      S_B:     st = 2'd1;
      S_OP:    st = 2'd2;
      default: st = 2'd3;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge detector producing a single-cycle pulse three edges after the rise.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pulse_reg <= sync2_reg & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from shared switches with one load button, drives the
// ALU from registered operands and latches its result and flags for display.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         WIDTH  = 4,
  parameter logic [3:0] MAX_OP = OP_SHR,
  localparam int        RES_W  = 2*WIDTH-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       op_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [RES_W-1:0] res_out,
  output logic [3:0]       flags_out,
  output logic [1:0]       stage,
  output logic             done,
  output logic             err
);

  logic load_pulse;

  sync_edge_detect u_load_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load),
    .pulse (load_pulse)
  );

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] a_reg,      a_next;
  logic [WIDTH-1:0] b_reg,      b_next;
  logic [3:0]       op_reg,     op_next;
  logic [RES_W-1:0] res_reg,    res_next;
  logic [3:0]       flags_reg,  flags_next;
  logic [1:0]       stage_reg,  stage_next;
  logic             done_reg,   done_next;
  logic             err_reg,    err_next;
  logic             bad_op;

  // Illegal opcode, or a divide/modulo whose divisor is already latched as zero.
  assign bad_op = (op_in > MAX_OP) ||
                  (((op_in == OP_DIV) || (op_in == OP_MOD)) && (b_reg == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      res_reg   <= '0;
      flags_reg <= '0;
      stage_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      res_reg   <= res_next;
      flags_reg <= flags_next;
      stage_reg <= stage_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    res_next   = res_reg;
    flags_next = flags_reg;
    done_next  = done_reg;
    err_next   = err_reg;

    case (state_reg)
      S_A: begin
        if (load_pulse) begin
          a_next     = data_in;
          state_next = S_B;
        end
      end
      S_B: begin
        if (load_pulse) begin
          b_next     = data_in;
          state_next = S_OP;
        end
      end
      S_OP: begin
        if (load_pulse) begin
          op_next = op_in;
          if (bad_op) begin
            err_next   = 1'b1;
            done_next  = 1'b1;
            res_next   = '0;
            flags_next = '0;
            state_next = S_SHOW;
          end else begin
            state_next = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // Pulses arriving here are dropped on purpose.
        res_next          = alu_result;
        flags_next[FLG_N] = alu_n;
        flags_next[FLG_Z] = alu_z;
        flags_next[FLG_C] = alu_c;
        flags_next[FLG_V] = alu_v;
        done_next         = 1'b1;
        state_next        = S_SHOW;
      end
      S_SHOW: begin
        if (load_pulse) begin
          done_next  = 1'b0;
          err_next   = 1'b0;
          a_next     = data_in;
          state_next = S_B;
        end
      end
      default: state_next = S_A;
    endcase

    if (clear) begin
      state_next = S_A;
      a_next     = '0;
      b_next     = '0;
      op_next    = '0;
      res_next   = '0;
      flags_next = '0;
      done_next  = 1'b0;
      err_next   = 1'b0;
    end

    stage_next = stage_of(state_next);
  end

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_opcode = op_reg;
  assign res_out    = res_reg;
  assign flags_out  = flags_reg;
  assign stage      = stage_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small ALU model attached.
// Each step checks visible outputs against hand-computed values.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int RES_W = 2*WIDTH-1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [3:0]       op_in = '0;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_opcode;
  logic [RES_W-1:0] alu_result;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic [RES_W-1:0] res_out;
  logic [3:0]       flags_out;
  logic [1:0]       stage;
  logic             done, err;

  int total = 0;
  int bad = 0;

  alu_operand_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clear      (clear),
    .data_in    (data_in),
    .op_in      (op_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .res_out    (res_out),
    .flags_out  (flags_out),
    .stage      (stage),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // ALU model: ADD only; every other opcode returns a marker value.
  logic [WIDTH:0] sum;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = 7'h55;
    alu_n      = 1'b1;
    alu_z      = 1'b1;
    alu_c      = 1'b1;
    alu_v      = 1'b1;
    if (alu_opcode == OP_ADD) begin
      alu_result = {2'b00, sum};
      alu_n      = sum[WIDTH-1];
      alu_z      = (sum[WIDTH-1:0] == '0);
      alu_c      = sum[WIDTH];
      alu_v      = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full button press: rise, capture on the 4th edge, release long enough to re-arm.
  task automatic press(input logic [3:0] d, input logic [3:0] o);
    data_in = d;
    op_in   = o;
    load    = 1'b1;
    repeat (4) tick();
    load = 1'b0;
    repeat (3) tick();
    $display("press data=%0d op=%0d -> stage=%0d done=%0b err=%0b res=%0d", d, o, stage, done, err, res_out);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_stage", stage, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_res", res_out, 0);
    check("rst_alu_a", alu_a, 0);
    #2 rst_n = 1'b1;
    tick();

    // ADD 3+5
    press(4'd3, 4'd0);
    check("add_stage_b", stage, 1);
    check("add_a", alu_a, 3);
    press(4'd5, 4'd0);
    check("add_stage_op", stage, 2);
    check("add_b", alu_b, 5);
    op_in = OP_ADD;
    load  = 1'b1;
    repeat (3) tick();
    check("add_pre_capture", stage, 2);
    tick();
    check("add_exec_stage", stage, 3);
    check("add_exec_done", done, 0);
    tick();
    check("add_done", done, 1);
    check("add_res", res_out, 8);
    check("add_flags", flags_out, 4'b1001);
    check("add_err", err, 0);
    load = 1'b0;
    repeat (3) tick();
    $display("add 3+5 -> res=%0d flags=%b", res_out, flags_out);

    // Divide by zero, starting from SHOW
    press(4'd7, 4'd0);
    check("div_restart_stage", stage, 1);
    check("div_restart_done", done, 0);
    check("div_held_res", res_out, 8);
    check("div_a", alu_a, 7);
    press(4'd0, 4'd0);
    op_in = OP_DIV;
    load  = 1'b1;
    repeat (4) tick();
    check("div_stage", stage, 3);
    check("div_err", err, 1);
    check("div_done", done, 1);
    check("div_res", res_out, 0);
    check("div_flags", flags_out, 0);
    load = 1'b0;
    tick();
    check("div_no_exec", res_out, 0);
    repeat (2) tick();
    $display("div 7/0 -> err=%0b res=%0d", err, res_out);

    // Illegal opcode
    press(4'd2, 4'd0);
    check("ill_err_cleared", err, 0);
    check("ill_a", alu_a, 2);
    press(4'd2, 4'd0);
    op_in = 4'b1100;
    load  = 1'b1;
    repeat (4) tick();
    check("ill_err", err, 1);
    check("ill_done", done, 1);
    check("ill_res", res_out, 0);
    check("ill_opcode", alu_opcode, 4'hc);
    load = 1'b0;
    repeat (3) tick();
    press(4'd9, 4'd0);
    check("ill_next_err", err, 0);
    check("ill_next_done", done, 0);
    check("ill_next_a", alu_a, 9);
    check("ill_next_stage", stage, 1);

    // ADD 9+1 through the press helper
    press(4'd1, 4'd0);
    press(4'd0, OP_ADD);
    check("add2_res", res_out, 10);
    check("add2_flags", flags_out, 4'b1000);
    check("add2_done", done, 1);

    // Async reset in the middle of EXEC
    press(4'd3, 4'd0);
    press(4'd4, 4'd0);
    op_in = OP_SUB;
    load  = 1'b1;
    repeat (4) tick();
    check("ar_in_exec", stage, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_res", res_out, 0);
    check("ar_flags", flags_out, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    check("ar_stage", stage, 0);
    check("ar_alu_a", alu_a, 0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("ar_after_release", stage, 0);
    $display("async reset during exec -> stage=%0d res=%0d", stage, res_out);

    // Held load: exactly one capture
    data_in = 4'd6;
    load    = 1'b1;
    repeat (3) tick();
    check("held_pre", stage, 0);
    tick();
    check("held_stage", stage, 1);
    check("held_a", alu_a, 6);
    data_in = 4'd11;
    repeat (16) tick();
    check("held_stays", stage, 1);
    check("held_no_b", alu_b, 0);
    load = 1'b0;
    repeat (3) tick();
    $display("held load -> stage=%0d a=%0d", stage, alu_a);

    // Clear wins over a simultaneous load pulse in S_OP
    press(4'd2, 4'd0);
    check("clr_in_op", stage, 2);
    op_in = 4'd5;
    load  = 1'b1;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_stage", stage, 0);
    check("clr_a", alu_a, 0);
    check("clr_b", alu_b, 0);
    check("clr_opcode", alu_opcode, 0);
    load = 1'b0;
    repeat (3) tick();
    check("clr_no_queue", stage, 0);
    $display("clear vs load -> stage=%0d opcode=%0d", stage, alu_opcode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
